// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } uart_tx_state_t;

  localparam int PARITY_NONE   = 32'd0;
  localparam int PARITY_EVEN   = 32'd1;
  localparam int PARITY_ODD    = 32'd2;
  localparam int MAX_DATA_BITS = 32'd9;

  // Even parity is the XOR of the payload; odd parity inverts it.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder; carry-out is discarded.
module adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic carry_s;

  // Ripple the carry from LSB to MSB.
  always_comb begin
    carry_s = 1'b0;
    sum     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/comparator_eq.sv
// N-bit equality comparator.
module comparator_eq #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = ~|(a ^ b);

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out right shift register; load wins over shift.
module shift_register_piso #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         q_lsb
);

  logic [N-1:0] q_r;

  // Load the payload or shift it toward bit 0, zero-filling from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {N{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else if (shift) begin
      q_r <= {1'b0, q_r[N-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q_lsb = q_r[0];

endmodule

// File: rtl/uart_tx.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop bits,
// with every bit boundary paced by baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic          ODD_PARITY = (PARITY == PARITY_ODD);

  uart_tx_state_t           state_r;
  logic                     tx_r;
  logic                     tx_ready_r;
  logic                     busy_r;
  logic                     parity_r;
  logic [CW-1:0]            bit_cnt_r;
  logic [CW-1:0]            stop_cnt_r;
  logic [CW-1:0]            bit_cnt_inc_s;
  logic [CW-1:0]            stop_cnt_inc_s;
  logic                     bit_last_s;
  logic                     stop_last_s;
  logic                     load_s;
  logic                     shift_s;
  logic                     shift_lsb_s;
  logic [MAX_DATA_BITS-1:0] data_ext_s;

  // tx_ready_r is high only in S_IDLE, so this is the accepting handshake.
  assign load_s = tx_valid & tx_ready_r;

  adder_n #(.N(CW)) u_bit_inc (.a(bit_cnt_r), .b(CNT_ONE), .sum(bit_cnt_inc_s));
  adder_n #(.N(CW)) u_stop_inc (.a(stop_cnt_r), .b(CNT_ONE), .sum(stop_cnt_inc_s));
  comparator_eq #(.N(CW)) u_bit_last (.a(bit_cnt_r), .b(DATA_LAST), .eq(bit_last_s));
  comparator_eq #(.N(CW)) u_stop_last (.a(stop_cnt_r), .b(STOP_LAST), .eq(stop_last_s));

  shift_register_piso #(.N(DATA_BITS)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .shift (shift_s),
    .d     (tx_data),
    .q_lsb (shift_lsb_s)
  );

  // Zero-extend the payload for parity and shift only while sending data bits.
  always_comb begin
    data_ext_s                = {MAX_DATA_BITS{1'b0}};
    data_ext_s[DATA_BITS-1:0] = tx_data;
    case (state_r)
      S_DATA:  shift_s = baud_tick;
      default: shift_s = 1'b0;
    endcase
  end

  // Frame sequencer; tx reflects the state held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      parity_r   <= 1'b0;
      bit_cnt_r  <= CNT_ZERO;
      stop_cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        S_START:  tx_r <= 1'b0;
        S_DATA:   tx_r <= shift_lsb_s;
        S_PARITY: tx_r <= parity_r;
        default:  tx_r <= 1'b1;
      endcase

      case (state_r)
        S_IDLE: begin
          if (load_s) begin
            state_r    <= S_WAIT;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            parity_r   <= calc_parity(data_ext_s, ODD_PARITY);
          end
        end
        S_WAIT: begin
          if (baud_tick) state_r <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            state_r   <= S_DATA;
            bit_cnt_r <= CNT_ZERO;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            bit_cnt_r <= bit_cnt_inc_s;
            if (bit_last_s) begin
              state_r    <= HAS_PARITY ? S_PARITY : S_STOP;
              stop_cnt_r <= CNT_ZERO;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            state_r    <= S_STOP;
            stop_cnt_r <= CNT_ZERO;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_last_s) begin
              state_r    <= S_IDLE;
              tx_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              stop_cnt_r <= stop_cnt_inc_s;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          tx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) checked every cycle
// against a bit-queue line model, plus frame vectors and corner sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [2:0] valid_d;
  logic [2:0] ready_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [7:0] data_d [3];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_valid(valid_d[0]),
    .tx_data(data_d[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_8e2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_valid(valid_d[1]),
    .tx_data(data_d[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_valid(valid_d[2]),
    .tx_data(data_d[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 2, 1};

  // Model: frame bits waiting to go out, the bit currently on the line,
  // and the registered copy visible on tx one cycle later.
  bit         m_idle [3];
  bit         m_line [3];
  bit         m_tx   [3];
  bit         m_acc  [3];
  bit         m_q    [3][$];
  logic [7:0] drv_q  [3][$];

  int n_chk  = 0;
  int n_fail = 0;
  int tick_mode, tick_per, tick_ph;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] bits;
    int          len;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idle[k] = 1'b1;
      m_line[k] = 1'b1;
      m_tx[k]   = 1'b1;
      m_acc[k]  = 1'b0;
      m_q[k].delete();
    end
  endtask

  task automatic build_frame(input int k, input logic [7:0] d);
    int ones = 0;
    m_q[k].push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      m_q[k].push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par_cfg[k] == 1) m_q[k].push_back((ones % 2) == 1);
    if (par_cfg[k] == 2) m_q[k].push_back((ones % 2) == 0);
    for (int s = 0; s < stop_cfg[k]; s++) m_q[k].push_back(1'b1);
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 1'b0;
      if (!rst_n) begin
        m_idle[k] = 1'b1;
        m_line[k] = 1'b1;
        m_tx[k]   = 1'b1;
        m_q[k].delete();
      end else begin
        m_tx[k] = m_line[k];
        if (m_idle[k]) begin
          if (valid_d[k]) begin
            build_frame(k, data_d[k]);
            m_idle[k] = 1'b0;
            m_acc[k]  = 1'b1;
          end
        end else if (baud_tick) begin
          if (m_q[k].size() == 0) begin
            m_idle[k] = 1'b1;
            m_line[k] = 1'b1;
          end else begin
            m_line[k] = m_q[k].pop_front();
          end
        end
      end
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 3; k++) begin
      valid_d[k] = (drv_q[k].size() > 0);
      data_d[k]  = (drv_q[k].size() > 0) ? drv_q[k][0] : 8'h00;
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    drv_q[k].push_back(d);
    drive_inputs();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx_dut%0d", k), 32'(tx_w[k]), 32'(m_tx[k]));
      chk($sformatf("tx_ready_dut%0d", k), 32'(ready_w[k]), 32'(m_idle[k]));
      chk($sformatf("busy_dut%0d", k), 32'(busy_w[k]), 32'(!m_idle[k]));
      if (m_acc[k]) void'(drv_q[k].pop_front());
    end
    drive_inputs();
    case (tick_mode)
      0: begin
        tick_ph   = (tick_ph + 1) % tick_per;
        baud_tick = (tick_ph == 0);
      end
      1:       baud_tick = ($urandom_range(0, 3) == 0);
      2:       baud_tick = 1'b1;
      default: baud_tick = 1'b0;
    endcase
  endtask

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!m_idle[k] || drv_q[k].size() > 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_idle() && n < 2000) begin
      cycle();
      n++;
    end
    chk("wait_idle_bound", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_fall(input int k);
    int n = 0;
    while (tx_w[k] !== 1'b0 && n < 400) begin
      cycle();
      n++;
    end
    chk($sformatf("start_bit_seen_dut%0d", k), 32'(n < 400), 32'd1);
  endtask

  // Sample mid-bit with ticks every 4 clocks, then check ready at frame end.
  task automatic capture(input int k, input logic [11:0] exp_bits, input int len, input string name);
    logic [11:0] got;
    got = 12'h000;
    wait_fall(k);
    for (int i = 0; i < len; i++) begin
      repeat (2) cycle();
      got[i] = tx_w[k];
      if (i < len - 1) repeat (2) cycle();
    end
    cycle();
    chk({name, "_frame"}, 32'(got), 32'(exp_bits));
    chk({name, "_ready_after_stop"}, 32'(ready_w[k]), 32'd1);
  endtask

  initial begin
    logic hold_v;
    vecs[0] = '{0, 8'hA5, 12'b001101001010, 10};
    vecs[1] = '{1, 8'h07, 12'b111000001110, 12};
    vecs[2] = '{2, 8'h07, 12'b010000001110, 11};
    vecs[3] = '{1, 8'h00, 12'b110000000000, 12};
    vecs[4] = '{2, 8'hFF, 12'b011111111110, 11};
    vecs[5] = '{0, 8'h3C, 12'b001001111000, 10};

    rst_n     = 1'b1;
    baud_tick = 1'b0;
    tick_mode = 0;
    tick_per  = 4;
    tick_ph   = 0;
    model_reset();
    drive_inputs();
    #1 rst_n = 1'b0;

    // Reset held with tx_valid high: nothing may be accepted.
    for (int k = 0; k < 3; k++) push(k, 8'h5A);
    repeat (3) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

    for (int v = 0; v < 6; v++) begin
      tick_mode = 0;
      tick_per  = 4;
      push(vecs[v].dut, vecs[v].data);
      capture(vecs[v].dut, vecs[v].bits, vecs[v].len, $sformatf("vec%0d", v));
      wait_idle();
    end

    // Second byte offered mid-frame must wait and follow intact.
    push(0, 8'hA5);
    push(0, 8'h3C);
    capture(0, 12'b001101001010, 10, "stall_first");
    capture(0, 12'b001001111000, 10, "stall_second");
    wait_idle();

    // Handshake edge coincides with a tick; ticks stay high for the frame.
    tick_mode = 2;
    baud_tick = 1'b1;
    push(2, 8'hC3);
    cycle();
    chk("coinc_busy", 32'(busy_w[2]), 32'd1);
    chk("coinc_wait_tx", 32'(tx_w[2]), 32'd1);
    cycle();
    chk("coinc_no_early_start", 32'(tx_w[2]), 32'd1);
    cycle();
    chk("coinc_start_bit", 32'(tx_w[2]), 32'd0);
    wait_idle();

    // Ticks stop mid-frame: the current bit is held.
    tick_mode = 0;
    tick_per  = 4;
    push(1, 8'h96);
    wait_fall(1);
    repeat (6) cycle();
    tick_mode = 3;
    baud_tick = 1'b0;
    hold_v    = tx_w[1];
    repeat (30) cycle();
    chk("no_tick_hold_tx", 32'(tx_w[1]), 32'(hold_v));
    chk("no_tick_busy", 32'(busy_w[1]), 32'd1);
    tick_mode = 0;
    wait_idle();

    // Asynchronous reset during data bit 3, then a clean frame.
    push(0, 8'hA5);
    wait_fall(0);
    repeat (17) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("async_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("async_rst_ready", 32'(ready_w[0]), 32'd1);
    repeat (2) cycle();
    rst_n = 1'b1;
    push(0, 8'h55);
    capture(0, 12'b001010101010, 10, "after_reset");
    wait_idle();

    // Random traffic under changing tick patterns.
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        tick_mode = $urandom_range(0, 3);
        tick_per  = $urandom_range(1, 6);
        tick_ph   = 0;
      end
      for (int k = 0; k < 3; k++) begin
        if (drv_q[k].size() < 2 && $urandom_range(0, 7) == 0) push(k, 8'($urandom_range(0, 255)));
      end
      cycle();
    end
    tick_mode = 0;
    tick_per  = 4;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter, directly downstream of the baud-rate pulse generator.
- The pulse generator's one-cycle `out` pulse drives `baud_tick`; each pulse marks one bit boundary.
- Accepts parallel bytes over a valid/ready handshake and shifts out standard asynchronous frames, LSB first: start, data, optional parity, stop.
- Feeds the board-level UART pin.

Parameters:
- DATA_BITS, 8, payload width per frame (5..9).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-cycle pulse per bit period, from the pulse generator.
- tx_valid  input  1  upstream has a byte on tx_data.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  frame in progress (any state other than S_IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): state S_IDLE, tx=1, tx_ready=1, busy=0, shift register and counters cleared. Reset mid-frame aborts the frame; tx returns high immediately.
- Handshake:
  - Accept when tx_valid & tx_ready at a posedge.
  - tx_data latches into the shift register; parity bit computed and latched the same edge.
  - tx_ready is low from the next cycle until the frame ends.
  - tx_valid while tx_ready=0 is ignored; upstream must hold the data.
- FSM states, all advancing only on clock edges where baud_tick=1 (except S_IDLE):
  - S_IDLE: tx=1, tx_ready=1. Handshake -> S_WAIT, independent of baud_tick that cycle.
  - S_WAIT: tx=1. baud_tick -> S_START. This aligns the start bit to a bit boundary; latency from handshake to falling tx is 1 cycle after the next baud_tick.
  - S_START: tx=0. baud_tick -> S_DATA, bit_cnt=0.
  - S_DATA: tx=shift[0].
    - baud_tick shifts right one bit and increments bit_cnt.
    - When bit_cnt == DATA_BITS-1 on a tick: -> S_PARITY if PARITY!=0, else S_STOP.
  - S_PARITY: tx = latched parity (even: XOR of data; odd: its inverse). baud_tick -> S_STOP, stop_cnt=0.
  - S_STOP: tx=1.
    - baud_tick with stop_cnt == STOP_BITS-1 -> S_IDLE.
    - Otherwise increment stop_cnt.
- tx is registered: it changes the cycle after the edge that changes state.
- Frame length in bit periods: 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS.
- Back-to-back: a handshake is possible in the first S_IDLE cycle after the stop bit ends; the next start bit then waits for the following tick. Throughput is one frame per (frame length + 1) ticks worst case.
- baud_tick held high continuously (ticks=1 upstream): one bit per clock; FSM must still be correct.
- baud_tick never asserted: block holds its current bit indefinitely; no timeout.
- Counters: bit_cnt and stop_cnt are ceil(log2(DATA_BITS+1)) bits wide and wrap-free by construction. Increments use adder_n; end tests use comparator_eq. No behavioural +, -, == or relational operators.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_t {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP}.
  - Constants PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2.
- One sub-module: shift_register_piso.
  - Parameter N; ports clk, rst_n, load, shift, d[N-1:0], q_lsb.
  - Parallel load on load; right shift on shift; load has priority.
- Existing adder_n and comparator_eq are reused for the counters.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0 throughout; no handshake taken.
- Basic frame: ticks every 4 clocks, 8N1, send 0xA5 -> tx sequence 0, 1,0,1,0,0,1,0,1, 1, each value held exactly 4 cycles (40 cycles); tx_ready returns to 1 after the stop bit.
- Parity/stop variants:
  - PARITY=1, STOP_BITS=2, send 0x07 -> parity bit 1, then two stop bits (12 bit periods).
  - PARITY=2, send 0x07 -> parity bit 0.
- Handshake stall: assert tx_valid with 0x3C mid-frame of 0xA5 -> 0x3C is not taken until tx_ready=1; both frames appear intact and in order.
- Tick coincident with handshake: baud_tick=1 on the accept edge -> FSM goes to S_WAIT; start bit begins only on the next tick, never the same cycle.
- Async reset mid-frame: drop rst_n during data bit 3 (between clock edges) -> tx=1 and busy=0 immediately, no partial frame completes; a later send of 0x55 is correct.
